// File: rtl/data_sram_ctrl_pkg.sv
// Shared definitions for the MEM-stage data SRAM controller: state encoding,
// wait-counter width and the idle levels of the active-low SRAM strobes.
package data_sram_ctrl_pkg;
  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_ACCESS = 2'd1,
    S_DONE   = 2'd2
  } state_t;

  localparam int         CNT_W   = 4;
  localparam logic       STB_OFF = 1'b1;
  localparam logic [3:0] BE_OFF  = 4'hF;
endpackage

// File: rtl/dsram_wbuf.sv
// Single-entry store buffer: holds one posted store (word address, byte
// selects, data) plus a valid flag that stays set until the drain finishes.
module dsram_wbuf #(
  parameter int ADDR_W = 20
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cap,
  input  logic              clr,
  input  logic [ADDR_W-1:0] addr,
  input  logic [3:0]        sel,
  input  logic [31:0]       data,
  output logic              vld,
  output logic [ADDR_W-1:0] addr_q,
  output logic [3:0]        sel_q,
  output logic [31:0]       data_q
);
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vld    <= 1'b0;
      addr_q <= '0;
      sel_q  <= '0;
      data_q <= '0;
    end else if (cap) begin
      vld    <= 1'b1;
      addr_q <= addr;
      sel_q  <= sel;
      data_q <= data;
    end else if (clr) begin
      vld    <= 1'b0;
    end
  end
endmodule

// File: rtl/data_sram_ctrl.sv
// MEM-stage responder driving an asynchronous byte-enabled SRAM with a fixed
// strobe width. Define DSRAM_WBUF_EN to compile in a one-entry posted-store buffer.
module data_sram_ctrl
  import data_sram_ctrl_pkg::*;
#(
  parameter int WAIT_CYCLES = 2,
  parameter int ADDR_W      = 20
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              mem_ce_i,
  input  logic              mem_we_i,
  input  logic [3:0]        mem_sel_i,
  input  logic [31:0]       mem_addr_i,
  input  logic [31:0]       mem_data_i,
  input  logic              stall_i,
  output logic [31:0]       mem_data_o,
  output logic              stall_req_o,
  output logic [ADDR_W-1:0] sram_addr_o,
  output logic [31:0]       sram_data_o,
  input  logic [31:0]       sram_data_i,
  output logic              sram_ce_n_o,
  output logic              sram_oe_n_o,
  output logic              sram_we_n_o,
  output logic [3:0]        sram_be_n_o
);
  localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(WAIT_CYCLES - 1);

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q;
  logic [31:0]      rdata_q;
  logic             stall_d, start, finish, wb_vld;
  logic             unused_addr;

  assign unused_addr = ^{mem_addr_i[31:ADDR_W+2], mem_addr_i[1:0]};

`ifdef DSRAM_WBUF_EN
  logic              buf_cap;
  logic [ADDR_W-1:0] wb_addr;
  logic [3:0]        wb_sel;
  logic [31:0]       wb_data;

  dsram_wbuf #(.ADDR_W(ADDR_W)) u_wbuf (
    .clk    (clk),
    .rst    (rst),
    .cap    (buf_cap),
    .clr    (finish),
    .addr   (mem_addr_i[ADDR_W+1:2]),
    .sel    (mem_sel_i),
    .data   (mem_data_i),
    .vld    (wb_vld),
    .addr_q (wb_addr),
    .sel_q  (wb_sel),
    .data_q (wb_data)
  );
`else
  assign wb_vld = 1'b0;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= S_IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    stall_d = 1'b0;
    start   = 1'b0;
    finish  = 1'b0;
`ifdef DSRAM_WBUF_EN
    buf_cap = 1'b0;
`endif
    case (state_q)
      S_IDLE: begin
        if (mem_ce_i) begin
`ifdef DSRAM_WBUF_EN
          // posted store: the pipeline never sees a stall for it
          if (mem_we_i) begin
            if (!stall_i) begin
              buf_cap = 1'b1;
              start   = 1'b1;
              state_d = S_ACCESS;
            end
          end else
`endif
          begin
            stall_d = 1'b1;
            start   = 1'b1;
            state_d = S_ACCESS;
          end
        end
      end
      S_ACCESS: begin
        stall_d = 1'b1;
        if (cnt_q == '0) begin
          finish  = 1'b1;
          state_d = wb_vld ? S_IDLE : S_DONE;
        end
      end
      S_DONE: begin
        if (!stall_i) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // the combinational request must be quiet while reset is held
  assign stall_req_o = stall_d & ~rst;
  assign mem_data_o  = rdata_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sram_addr_o <= '0;
      sram_data_o <= '0;
      sram_ce_n_o <= STB_OFF;
      sram_oe_n_o <= STB_OFF;
      sram_we_n_o <= STB_OFF;
      sram_be_n_o <= BE_OFF;
      cnt_q       <= '0;
      rdata_q     <= '0;
    end else if (start) begin
      sram_addr_o <= mem_addr_i[ADDR_W+1:2];
      sram_data_o <= mem_data_i;
      sram_be_n_o <= ~mem_sel_i;
      sram_ce_n_o <= 1'b0;
      sram_oe_n_o <= mem_we_i;
      sram_we_n_o <= ~mem_we_i;
      cnt_q       <= CNT_INIT;
    end else if (finish) begin
      if (!sram_oe_n_o) rdata_q <= sram_data_i;
      sram_ce_n_o <= STB_OFF;
      sram_oe_n_o <= STB_OFF;
      sram_we_n_o <= STB_OFF;
      sram_be_n_o <= BE_OFF;
    end else if (state_q == S_ACCESS) begin
      cnt_q <= cnt_q - 1'b1;
`ifdef DSRAM_WBUF_EN
      if (wb_vld) begin
        sram_addr_o <= wb_addr;
        sram_data_o <= wb_data;
        sram_be_n_o <= ~wb_sel;
      end
`endif
    end
  end
endmodule

// File: tb/tb_data_sram_ctrl.sv
// Self-checking bench for data_sram_ctrl: pin-level async SRAM model plus a
// word-array reference memory updated by byte-select store semantics.
module tb_data_sram_ctrl;
  localparam int WAIT = 2;
  localparam int AW   = 20;

  logic          clk = 1'b0;
  logic          rst;
  logic          mem_ce_i, mem_we_i, stall_i;
  logic [3:0]    mem_sel_i;
  logic [31:0]   mem_addr_i, mem_data_i;
  logic [31:0]   mem_data_o, sram_data_o, sram_data_i;
  logic          stall_req_o, sram_ce_n_o, sram_oe_n_o, sram_we_n_o;
  logic [AW-1:0] sram_addr_o;
  logic [3:0]    sram_be_n_o;

  data_sram_ctrl #(.WAIT_CYCLES(WAIT), .ADDR_W(AW)) dut (
    .clk(clk), .rst(rst), .mem_ce_i(mem_ce_i), .mem_we_i(mem_we_i),
    .mem_sel_i(mem_sel_i), .mem_addr_i(mem_addr_i), .mem_data_i(mem_data_i),
    .stall_i(stall_i), .mem_data_o(mem_data_o), .stall_req_o(stall_req_o),
    .sram_addr_o(sram_addr_o), .sram_data_o(sram_data_o), .sram_data_i(sram_data_i),
    .sram_ce_n_o(sram_ce_n_o), .sram_oe_n_o(sram_oe_n_o), .sram_we_n_o(sram_we_n_o),
    .sram_be_n_o(sram_be_n_o)
  );

  always #5 clk = ~clk;

  logic [31:0] sram    [256];
  logic [31:0] ref_mem [256];
`ifdef DSRAM_WBUF_EN
  localparam bit WBUF = 1'b1;
`else
  localparam bit WBUF = 1'b0;
`endif

  int n_assert = 0, n_fail = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // SRAM pin model: a write lands only if its strobe window lasted the full WAIT cycles
  assign sram_data_i = (!sram_ce_n_o && !sram_oe_n_o) ? sram[sram_addr_o[7:0]] : 32'h5A5A_5A5A;

  int          run_len = 0, last_len = 0, n_reads = 0, n_writes = 0, n_commits = 0;
  logic        prev_act = 1'b0, unstable = 1'b0, w_rd = 1'b0, w_wr = 1'b0;
  logic [AW-1:0] w_addr = '0;
  logic [3:0]  w_be = '0;
  logic [31:0] w_data = '0;

  always @(negedge clk) begin
    if (!sram_ce_n_o) begin
      if (!prev_act) begin
        run_len = 1; w_addr = sram_addr_o; w_be = sram_be_n_o; w_data = sram_data_o;
        w_rd = !sram_oe_n_o; w_wr = !sram_we_n_o; unstable = 1'b0;
        if (w_rd) n_reads++;
        if (w_wr) n_writes++;
      end else begin
        run_len++;
        if (sram_addr_o !== w_addr || sram_be_n_o !== w_be || sram_data_o !== w_data ||
            sram_oe_n_o !== !w_rd || sram_we_n_o !== !w_wr) unstable = 1'b1;
      end
      prev_act = 1'b1;
    end else begin
      if (prev_act) begin
        last_len = run_len;
        if (w_wr && run_len >= WAIT) begin
          for (int b = 0; b < 4; b++)
            if (!w_be[b]) sram[w_addr[7:0]][8*b +: 8] = w_data[8*b +: 8];
          n_commits++;
        end
      end
      prev_act = 1'b0;
    end
  end

  function automatic void ref_store(input logic [31:0] a, input logic [3:0] s, input logic [31:0] d);
    for (int b = 0; b < 4; b++)
      if (s[b]) ref_mem[a[9:2]][8*b +: 8] = d[8*b +: 8];
  endfunction

  // MEM-side view: present, ride out the stall, sample the word, let the pipeline advance
  task automatic access(input logic we, input logic [31:0] a, input logic [3:0] s,
                        input logic [31:0] d, output logic [31:0] rd, output int stalls);
    mem_ce_i = 1'b1; mem_we_i = we; mem_addr_i = a; mem_sel_i = s; mem_data_i = d;
    stalls = 0;
    @(negedge clk);
    while (stall_req_o && stalls < 40) begin stalls++; @(negedge clk); end
    if (stalls >= 40) chk("stall_timeout", 32'(stalls), 32'(1 + WAIT));
    rd = mem_data_o;
    @(posedge clk); #1;
    mem_ce_i = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  logic [31:0] rd, old;
  int stalls, r0, c0, nmis, guard;
  logic we;
  logic [31:0] a, d;
  logic [3:0] s;

  initial begin
    rst = 1'b1; mem_ce_i = 1'b0; mem_we_i = 1'b0; mem_sel_i = 4'h0;
    mem_addr_i = '0; mem_data_i = '0; stall_i = 1'b0;
    for (int i = 0; i < 256; i++) begin sram[i] = $urandom; ref_mem[i] = sram[i]; end
    sram[8'h10] = 32'h1234_5678; ref_mem[8'h10] = 32'h1234_5678;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("rst_stall", {31'b0, stall_req_o}, 32'd0);
    chk("rst_rdata", mem_data_o, 32'd0);
    chk("rst_strobes", {29'b0, sram_ce_n_o, sram_oe_n_o, sram_we_n_o}, 32'h7);
    chk("rst_be", {28'b0, sram_be_n_o}, 32'hF);
    chk("rst_addr_data", {12'b0, sram_addr_o} | sram_data_o, 32'd0);
    @(posedge clk); #1;

    // load 0x40 -> word 0x10
    r0 = n_reads;
    access(1'b0, 32'h0000_0040, 4'hF, 32'h0, rd, stalls);
    chk("ld_stall_cycles", 32'(stalls), 32'(1 + WAIT));
    chk("ld_data", rd, 32'h1234_5678);
    chk("ld_window_len", 32'(last_len), 32'(WAIT));
    chk("ld_window_addr", {12'b0, w_addr}, 32'h10);
    chk("ld_oe_active", {31'b0, w_rd}, 32'd1);
    chk("ld_window_stable", {31'b0, unstable}, 32'd0);
    chk("ld_one_read", 32'(n_reads - r0), 32'd1);

    // byte-lane store: only byte 2 of word 0x20 changes
    old = ref_mem[8'h20];
    access(1'b1, 32'h0000_0082, 4'b0100, 32'h00AB_0000, rd, stalls);
    chk("st_stall_cycles", 32'(stalls), WBUF ? 32'd0 : 32'(1 + WAIT));
    idle(WAIT + 2);
    ref_store(32'h0000_0082, 4'b0100, 32'h00AB_0000);
    chk("st_be", {28'b0, w_be}, 32'b1011);
    chk("st_we_active", {31'b0, w_wr}, 32'd1);
    chk("st_window_len", 32'(last_len), 32'(WAIT));
    chk("st_word", sram[8'h20], {old[31:24], 8'hAB, old[15:0]});

    // load finishing while another source holds the pipeline
    r0 = n_reads;
    mem_ce_i = 1'b1; mem_we_i = 1'b0; mem_addr_i = 32'h0000_0040; mem_sel_i = 4'hF;
    stalls = 0;
    @(negedge clk);
    while (stall_req_o && stalls < 40) begin stalls++; @(negedge clk); end
    chk("hold_stall_cycles", 32'(stalls), 32'(1 + WAIT));
    chk("hold_done_data", mem_data_o, 32'h1234_5678);
    stall_i = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk("hold_no_stall", {31'b0, stall_req_o}, 32'd0);
      chk("hold_data", mem_data_o, 32'h1234_5678);
    end
    stall_i = 1'b0;
    @(posedge clk); #1 mem_ce_i = 1'b0;
    idle(3);
    chk("hold_one_read", 32'(n_reads - r0), 32'd1);
    chk("hold_strobes_idle", {31'b0, sram_ce_n_o}, 32'd1);

    // back-to-back loads
    r0 = n_reads;
    access(1'b0, 32'h0, 4'hF, 32'h0, rd, stalls);
    chk("b2b0_data", rd, ref_mem[0]);
    chk("b2b0_len", 32'(last_len), 32'(WAIT));
    access(1'b0, 32'h4, 4'hF, 32'h0, rd, stalls);
    chk("b2b1_data", rd, ref_mem[1]);
    chk("b2b1_len", 32'(last_len), 32'(WAIT));
    chk("b2b_reads", 32'(n_reads - r0), 32'd2);

    // no lanes enabled: normal latency, nothing written
    c0 = n_commits; old = sram[8'h30];
    access(1'b1, 32'h0000_00C0, 4'b0000, 32'hFFFF_FFFF, rd, stalls);
    chk("sel0_stall", 32'(stalls), WBUF ? 32'd0 : 32'(1 + WAIT));
    idle(WAIT + 2);
    chk("sel0_len", 32'(last_len), 32'(WAIT));
    chk("sel0_word", sram[8'h30], old);

`ifdef DSRAM_WBUF_EN
    access(1'b1, 32'h0000_0010, 4'hF, 32'hDEAD_BEEF, rd, stalls);
    chk("wb_store_nostall", 32'(stalls), 32'd0);
    ref_store(32'h0000_0010, 4'hF, 32'hDEAD_BEEF);
    access(1'b0, 32'h0000_0010, 4'hF, 32'h0, rd, stalls);
    chk("wb_load_stall", 32'(stalls), 32'(2 * WAIT + 1));
    chk("wb_load_data", rd, 32'hDEAD_BEEF);
`endif

    // reset in the middle of a store to 0x100
    c0 = n_commits; old = sram[8'h40];
    mem_ce_i = 1'b1; mem_we_i = 1'b1; mem_addr_i = 32'h0000_0100;
    mem_sel_i = 4'hF; mem_data_i = 32'hCAFE_F00D;
    guard = 0;
    @(negedge clk);
    while (sram_ce_n_o && guard < 10) begin guard++; @(negedge clk); end
    chk("rst_mid_entered", {31'b0, sram_we_n_o}, 32'd0);
    #2 rst = 1'b1;
    #1;
    chk("rst_mid_strobes", {29'b0, sram_ce_n_o, sram_oe_n_o, sram_we_n_o}, 32'h7);
    chk("rst_mid_be", {28'b0, sram_be_n_o}, 32'hF);
    chk("rst_mid_stall", {31'b0, stall_req_o}, 32'd0);
    chk("rst_mid_rdata", mem_data_o, 32'd0);
    mem_ce_i = 1'b0;
    @(posedge clk); #1 rst = 1'b0;
    idle(WAIT + 2);
    chk("rst_mid_no_commit", 32'(n_commits - c0), 32'd0);
    chk("rst_mid_word", sram[8'h40], old);

    // randomized traffic against the reference memory
    for (int i = 0; i < 40; i++) begin
      we = 1'($urandom_range(0, 1));
      a  = {22'b0, 8'($urandom_range(0, 255)), 2'($urandom_range(0, 3))};
      s  = 4'($urandom);
      d  = $urandom;
      access(we, a, s, d, rd, stalls);
      if (we) begin
        ref_store(a, s, d);
        chk("rnd_st_stall", 32'(stalls), WBUF ? 32'd0 : 32'(1 + WAIT));
        if (!WBUF) chk("rnd_st_len", 32'(last_len), 32'(WAIT));
      end else begin
        chk("rnd_ld_data", rd, ref_mem[a[9:2]]);
        chk("rnd_ld_len", 32'(last_len), 32'(WAIT));
        if (WBUF) chk("rnd_ld_stall_min", {31'b0, stalls >= 1 + WAIT}, 32'd1);
        else      chk("rnd_ld_stall", 32'(stalls), 32'(1 + WAIT));
      end
    end
    idle(WAIT + 3);

    nmis = 0;
    for (int i = 0; i < 256; i++) if (sram[i] !== ref_mem[i]) nmis++;
    chk("final_mem_mismatch_words", 32'(nmis), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule
